// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: opcodes,
// instruction layout, controller states and flag-vector bit positions.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_REG = 4;
    localparam int INSTR_W = 16;

    // Opcode field, fully decoded (all 8 codes defined)
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_CMP = 3'd7
    } opcode_e;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 9;
    localparam int IMM_SEL = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Packed view of an instruction; field order matches the bit layout above
    typedef struct packed {
        opcode_e     op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic        use_imm;
        logic [7:0]  imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Flag vector layout {overflow, carry, zero}
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_CARRY    = 1;
    localparam int FLAG_OVERFLOW = 2;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU. Carry is bit 8 of the operation (borrow for
// SUB/CMP, shifted-out bit for shifts); overflow is signed overflow for
// ADD/SUB/CMP and 0 otherwise. Shifts are by one and ignore b.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_e           opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Result, carry and signed overflow selected by opcode
    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                result   = w_sum[DATA_W-1:0];
                carry    = w_sum[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                result   = w_diff[DATA_W-1:0];
                carry    = w_diff[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                           (w_diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_ctrl.sv
// Instruction-issue controller: one instruction per handshake, operands
// from a 4x8 register file, result written back on the EXEC edge and
// returned with its flags on a valid/ready response channel.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [2:0]         out_flags,
    output logic [2:0]         flags,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e                           r_state;
    instr_t                           r_instr;
    logic [NUM_REG-1:0][DATA_W-1:0]   r_regs;
    logic                             r_in_ready;
    logic                             r_out_valid;
    logic [DATA_W-1:0]                r_out_result;
    logic [2:0]                       r_out_flags;
    logic [2:0]                       r_flags;

    logic [DATA_W-1:0]                w_a;
    logic [DATA_W-1:0]                w_b;
    logic [DATA_W-1:0]                w_result;
    logic                             w_zero;
    logic                             w_carry;
    logic                             w_ovf;
    logic [2:0]                       w_alu_flags;
    logic                             w_wr_en;

    // Operand read from the latched instruction; only meaningful in EXEC
    assign w_a = r_regs[r_instr.rd];
    assign w_b = r_instr.use_imm ? r_instr.imm : r_regs[r_instr.rs];

    alu u_alu (
        .a        (w_a),
        .b        (w_b),
        .opcode   (r_instr.op),
        .result   (w_result),
        .zero     (w_zero),
        .carry    (w_carry),
        .overflow (w_ovf)
    );

    assign w_alu_flags[FLAG_ZERO]     = w_zero;
    assign w_alu_flags[FLAG_CARRY]    = w_carry;
    assign w_alu_flags[FLAG_OVERFLOW] = w_ovf;

    // CMP only updates flags/response, never the destination register
    assign w_wr_en = (r_state == ST_EXEC) && (r_instr.op != OP_CMP);

    // Issue FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_instr      <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_flags      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_instr    <= instr_t'(in_instr);
                        r_in_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_out_result <= w_result;
                    r_out_flags  <= w_alu_flags;
                    r_flags      <= w_alu_flags;
                    r_out_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Register file write-back on the EXEC edge; reset wins over the write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '0;
        end else if (w_wr_en) begin
            r_regs[r_instr.rd] <= w_result;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;
    assign flags      = r_flags;
    assign dbg_data   = r_regs[dbg_sel];

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Instruction-issue controller that sits in front of the team's 8-bit combinational ALU, the `alu` module. It accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal 4×8 register file. It drives the ALU's opcode and operands, writes the result back, latches the flags, and returns result plus flags on a valid/ready response channel.

## Interface
- No parameters. Data width 8, register count 4, fixed.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset. Synchronous, active-high; one clock; reset is synchronous and active-high.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  controller can accept an instruction.
- `in_instr`  in  16  instruction bits, laid out as follows:
  - [15:13] opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, CMP=7.
  - [12:11] rd.
  - [10:9] rs.
  - [8] use_imm.
  - [7:0] imm.
- `out_valid`  out  1  response available.
- `out_ready`  in  1  response consumer ready.
- `out_result`  out  8  ALU result for the instruction.
- `out_flags`  out  3  {overflow, carry, zero} for the instruction.
- `flags`  out  3  persistent flag register {overflow, carry, zero}.
- `dbg_sel`  in  2  register index for debug read.
- `dbg_data`  out  8  combinational read of R[dbg_sel].

## Operation
- Two-operand form: a = R[rd]; b = use_imm ? imm : R[rs]; R[rd] ← a op b.
- ALU port mapping: a → `a`, b → `b`, opcode → `opcode`. The result and the zero/carry/overflow flags come straight from the ALU.
- CMP computes a − b and updates flags and the response, but never writes R[rd].
- Operations with no ALU flag definition (AND/OR/XOR) still update all three flags with the ALU's outputs; carry and overflow are 0 for these.
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid`, latch `in_instr` and go to EXEC.
  - EXEC: ALU evaluates on the latched instruction and registers are read. At the clock edge:
    - `out_result`, `out_flags` and `flags` load.
    - R[rd] writes unless opcode is CMP.
    - Go to RESP.
  - RESP: `out_valid`=1. When `out_ready`, go to IDLE. Otherwise hold.
- `out_result` and `out_flags` hold stable from entry to RESP until the handshake completes.
- `in_ready` is 0 in EXEC and RESP. An `in_valid` asserted there is ignored, not queued.
- Register hazard: none possible. Write-back completes before the next instruction is accepted.
- `dbg_data` reflects writes the cycle after the EXEC edge.
- Undefined/default handling: none needed, since the opcode field is fully decoded.

## Timing
- Reset (any state):
  - State goes to IDLE.
  - `in_ready`=1 from the first cycle after reset.
  - `out_valid`=0, `out_result`=0, `out_flags`=0, `flags`=0.
  - R0–R3 = 0.
- Reset during EXEC: `rst` dominates. No register write and no flag update occur.
- Latency: instruction accepted at edge N, `out_valid` high after edge N+1.
- Minimum issue interval is 3 cycles: IDLE, EXEC, RESP with `out_ready` high.
- Back-pressure: RESP holds indefinitely while `out_ready`=0.
- Simultaneous events: `rst` with `out_ready` in RESP takes reset, and the response is dropped.
- Width rules:
  - All arithmetic is 8-bit, wrap-around modulo 256.
  - Carry = ALU bit 8. For SUB/CMP that is the borrow.
  - Shifts are by 1 only.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants (ADD…CMP).
  - Instruction field positions/widths.
  - FSM state enum (IDLE, EXEC, RESP).
  - Flag-vector bit indices (ZERO=0, CARRY=1, OVERFLOW=2).
- Sub-module: instantiate the existing `alu` unchanged, once, combinationally between the latched instruction/register read and the EXEC-edge registers.
- Register file, FSM, instruction latch and response registers live in `alu_ctrl`. Target size is about 150–250 lines.

## Test plan
- Overflow: after reset, issue ADD R0,imm 0x7F, then ADD R0,imm 0x01.
  - Second response: result 0x80, flags {ovf=1, carry=0, zero=0}.
  - R0=0x80. `out_valid` two edges after acceptance.
- Borrow: R1=0, issue SUB R1,imm 0x01.
  - Result 0xFF, carry=1, ovf=0, zero=0.
  - R1=0xFF.
- CMP no-write: R2=0x5A, R3=0x5A, issue CMP R2,R3.
  - Result 0x00, zero=1.
  - R2 still 0x5A via `dbg_data`.
- Shift carry-out: R0=0x81, issue SHL R0.
  - Result 0x02, carry=1.
  - Then SHR R0 gives 0x01, carry=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles in RESP.
  - `out_result` and `out_flags` stable, `in_ready`=0.
  - An `in_valid` pulse during this window is not accepted.
  - Releasing `out_ready` returns to IDLE.
- Reset mid-operation: assert `rst` on the EXEC cycle of ADD R1,imm 0x10 with R1=0x05.
  - Afterwards R1=0x00 and `flags`=0, `out_valid`=0, `in_ready`=1.
